// File: rtl/axi_lite_arbiter.sv
// Two-master AXI-Lite read/write arbiter in front of a single AXI-Lite slave.
// Master 0 is a read-only instruction port; master 1 is a read/write data port.
// Exactly one transaction is in flight at a time; the FSM owns every handshake.
module axi_lite_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  // master 0: read only
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  // master 1: read and write
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  input  logic [31:0] m1_awaddr,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  // slave side
  output logic [31:0] s_araddr,
  output logic [2:0]  s_arprot,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic [2:0]  s_awprot,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_SEND, WR_RESP} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;        // owner of the current read: 0 = m0, 1 = m1
  logic        last_q, last_d;      // master granted most recently
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic req0, req1, wr1, pick1, idle;
  logic grant_rd0, grant_rd1, grant_wr;
  logic rready_sel;

  // Arbitration terms; a master-1 write beats its own pending read.
  assign idle       = (state_q == IDLE);
  assign req0       = m0_arvalid;
  assign wr1        = m1_awvalid & m1_wvalid;
  assign req1       = m1_arvalid | wr1;
  assign pick1      = req1 & (~req0 | FIXED_PRIORITY | ~last_q);
  assign grant_rd0  = idle & req0 & ~pick1;
  assign grant_rd1  = idle & pick1 & ~wr1;
  assign grant_wr   = idle & pick1 & wr1;
  assign rready_sel = gnt_q ? m1_rready : m0_rready;

  assign s_araddr = araddr_q;
  assign s_awaddr = awaddr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign s_arprot = 3'b000;
  assign s_awprot = 3'b000;
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_bresp = s_bresp;

  // State and latched request registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state: grant in IDLE, then follow the slave handshakes back to IDLE.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (grant_rd0) begin
          state_d  = RD_ADDR;
          gnt_d    = 1'b0;
          last_d   = 1'b0;
          araddr_d = m0_araddr;
        end else if (grant_rd1) begin
          state_d  = RD_ADDR;
          gnt_d    = 1'b1;
          last_d   = 1'b1;
          araddr_d = m1_araddr;
        end else if (grant_wr) begin
          state_d   = WR_SEND;
          last_d    = 1'b1;
          awaddr_d  = m1_awaddr;
          wdata_d   = m1_wdata;
          wstrb_d   = m1_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RD_ADDR: if (s_arready) state_d = RD_DATA;
      RD_DATA: if (s_rvalid && rready_sel) state_d = IDLE;
      WR_SEND: begin
        aw_done_d = aw_done_q | s_awready;
        w_done_d  = w_done_q | s_wready;
        if ((aw_done_q | s_awready) && (w_done_q | s_wready)) state_d = WR_RESP;
      end
      WR_RESP: if (s_bvalid && m1_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready only in the grant cycle, responses only to the owner.
  always_comb begin
    m0_arready = grant_rd0;
    m1_arready = grant_rd1;
    m1_awready = grant_wr;
    m1_wready  = grant_wr;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m1_bvalid  = 1'b0;
    case (state_q)
      RD_ADDR: s_arvalid = 1'b1;
      RD_DATA: begin
        s_rready  = rready_sel;
        m0_rvalid = ~gnt_q & s_rvalid;
        m1_rvalid = gnt_q & s_rvalid;
      end
      WR_SEND: begin
        s_awvalid = ~aw_done_q;
        s_wvalid  = ~w_done_q;
      end
      WR_RESP: begin
        s_bready  = m1_bready;
        m1_bvalid = s_bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: master drivers, a reactive slave and a
// scoreboard monitor that checks every handshake against queued expectations.
module tb_axi_lite_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] m0_araddr = '0, m1_araddr = '0, m1_awaddr = '0, m1_wdata = '0;
  logic        m0_arvalid = 0, m1_arvalid = 0, m1_awvalid = 0, m1_wvalid = 0;
  logic [3:0]  m1_wstrb = '0;
  logic        m0_rready = 1, m1_rready = 1, m1_bready = 1;
  logic        m0_arready, m1_arready, m1_awready, m1_wready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
  logic        m0_rvalid, m1_rvalid, m1_bvalid;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [2:0]  s_arprot, s_awprot;
  logic [3:0]  s_wstrb;
  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic        s_arready = 0, s_rvalid = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0, s_bresp = '0;

  axi_lite_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  localparam int CH_AR = 0, CH_AW = 1, CH_W = 2, CH_R0 = 3, CH_R1 = 4, CH_B = 5;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0;
  int gnt_cyc = 0, arv_cyc = 0, n_b = 0, ar1_bcnt = -1;
  logic [63:0] exq [6][$];
  logic [33:0] slv_r [$];
  logic [1:0]  slv_b [$];
  logic [31:0] slv_a0;
  logic        slv_awd, slv_wd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input int ch, input string nm, input logic [63:0] act);
    if (exq[ch].size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected handshake actual=%h required=none t=%0t", nm, act, $time);
    end else begin
      chk(nm, act, exq[ch].pop_front());
    end
  endtask

  // Scoreboard monitor: every handshake must match the head of its channel queue.
  initial forever begin
    @(negedge clk);
    if (s_arvalid && s_arready) pop_chk(CH_AR, "s_ar", 64'(s_araddr));
    if (s_awvalid && s_awready) pop_chk(CH_AW, "s_aw", 64'(s_awaddr));
    if (s_wvalid && s_wready)   pop_chk(CH_W, "s_w", 64'({s_wstrb, s_wdata}));
    if (m0_rvalid && m0_rready) pop_chk(CH_R0, "m0_r", 64'({m0_rresp, m0_rdata}));
    if (m1_rvalid && m1_rready) pop_chk(CH_R1, "m1_r", 64'({m1_rresp, m1_rdata}));
    if (m1_bvalid && m1_bready) begin
      pop_chk(CH_B, "m1_b", 64'(m1_bresp));
      n_b++;
    end
    if (m1_arvalid && m1_arready) ar1_bcnt = n_b;
  end

  // Slave read side: optional address stall, optional data delay.
  initial forever begin
    @(posedge clk); #1;
    if (reset_n && s_arvalid) begin
      slv_a0  = s_araddr;
      arv_cyc = cyc;
      for (int i = 0; i < ar_delay; i++) begin
        @(posedge clk); #1;
        chk("ar_stable", 64'({s_arvalid, s_araddr}), 64'({1'b1, slv_a0}));
        chk("no_ready_busy", 64'({m0_arready, m1_arready, m1_awready, m1_wready}), 64'd0);
      end
      s_arready = 1'b1;
      @(posedge clk); #1;
      s_arready = 1'b0;
      for (int i = 0; i < r_delay; i++) begin
        @(posedge clk); #1;
      end
      if (reset_n && slv_r.size() > 0) begin
        {s_rresp, s_rdata} = slv_r.pop_front();
        s_rvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (s_rready || !reset_n) break;
        end
        @(posedge clk); #1;
        s_rvalid = 1'b0;
      end
    end
  end

  // Slave write side: independent AW/W ready delays, then one B response.
  initial forever begin
    @(posedge clk); #1;
    if (reset_n && (s_awvalid || s_wvalid)) begin
      slv_awd = 1'b0;
      slv_wd  = 1'b0;
      for (int k = 0; k < 100; k++) begin
        chk("wr_valids", 64'({s_awvalid, s_wvalid}), 64'({~slv_awd, ~slv_wd}));
        s_awready = !slv_awd && (k >= aw_delay);
        s_wready  = !slv_wd && (k >= w_delay);
        @(posedge clk);
        if (s_awready) slv_awd = 1'b1;
        if (s_wready)  slv_wd  = 1'b1;
        #1;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        if (slv_awd && slv_wd) break;
      end
      if (reset_n && slv_b.size() > 0) begin
        s_bresp  = slv_b.pop_front();
        s_bvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (s_bready || !reset_n) break;
        end
        @(posedge clk); #1;
        s_bvalid = 1'b0;
      end
    end
  end

  task automatic m0_read(input logic [31:0] a);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    m0_araddr  = a;
    m0_arvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m0_arready) begin
        got = 1'b1;
        gnt_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    m0_arvalid = 1'b0;
    chk("m0_ar_grant", 64'(got), 64'd1);
  endtask

  task automatic m1_read(input logic [31:0] a);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    m1_araddr  = a;
    m1_arvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m1_arready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    m1_arvalid = 1'b0;
    chk("m1_ar_grant", 64'(got), 64'd1);
  endtask

  task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    m1_awaddr  = a;
    m1_wdata   = d;
    m1_wstrb   = s;
    m1_awvalid = 1'b1;
    m1_wvalid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m1_awready) begin
        got = 1'b1;
        chk("m1_wready_with_awready", 64'(m1_wready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    m1_awvalid = 1'b0;
    m1_wvalid  = 1'b0;
    chk("m1_aw_grant", 64'(got), 64'd1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exq[CH_AR].size() == 0 && exq[CH_AW].size() == 0 && exq[CH_W].size() == 0 &&
          exq[CH_R0].size() == 0 && exq[CH_R1].size() == 0 && exq[CH_B].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 64'(ok), 64'd1);
    repeat (2) @(posedge clk);
  endtask

  // Directed write table: delays, address, data, strobe, slave bresp.
  int          wt_awd [3] = '{0, 2, 1};
  int          wt_wd  [3] = '{2, 0, 1};
  logic [31:0] wt_a   [3] = '{32'h8000_0010, 32'h8000_0014, 32'h8000_0018};
  logic [31:0] wt_d   [3] = '{32'h1234_5678, 32'hA5A5_0F0F, 32'hFFFF_0000};
  logic [3:0]  wt_s   [3] = '{4'b0011, 4'b1100, 4'b1111};
  logic [1:0]  wt_b   [3] = '{2'b00, 2'b10, 2'b00};

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                           m0_rvalid, m1_rvalid, m1_bvalid}), 64'd0);
    chk("rst_addr", 64'({s_araddr, s_awaddr}), 64'd0);
    chk("rst_wdata", 64'({s_wstrb, s_wdata}), 64'd0);
    chk("prot", 64'({s_arprot, s_awprot}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // simultaneous reads, round-robin: m0 then m1, twice
    for (int r = 0; r < 2; r++) begin
      exq[CH_AR].push_back(64'h0000_0000_8000_0100 + 64'(r));
      exq[CH_AR].push_back(64'h0000_0000_8000_0200 + 64'(r));
      slv_r.push_back({2'b00, 32'h1111_1111});
      slv_r.push_back({2'b00, 32'h2222_2222});
      exq[CH_R0].push_back(64'h0000_0000_1111_1111);
      exq[CH_R1].push_back(64'h0000_0000_2222_2222);
      fork
        m0_read(32'h8000_0100 + 32'(r));
        m1_read(32'h8000_0200 + 32'(r));
      join
      drain();
    end

    // single read with latency check
    exq[CH_AR].push_back(64'h0000_0000_8000_0000);
    slv_r.push_back({2'b00, 32'hDEAD_BEEF});
    exq[CH_R0].push_back(64'h0000_0000_DEAD_BEEF);
    m0_read(32'h8000_0000);
    drain();
    chk("ar_latency", 64'(arv_cyc), 64'(gnt_cyc + 1));

    // writes with independent AW/W completion orders
    for (int t = 0; t < 3; t++) begin
      aw_delay = wt_awd[t];
      w_delay  = wt_wd[t];
      exq[CH_AW].push_back(64'(wt_a[t]));
      exq[CH_W].push_back(64'({wt_s[t], wt_d[t]}));
      exq[CH_B].push_back(64'(wt_b[t]));
      slv_b.push_back(wt_b[t]);
      m1_write(wt_a[t], wt_d[t], wt_s[t]);
      drain();
    end
    aw_delay = 0;
    w_delay  = 0;

    // m1 write and read together: write goes first
    begin
      int b_before;
      b_before = n_b;
      exq[CH_AW].push_back(64'h0000_0000_8000_0020);
      exq[CH_W].push_back(64'h0000_000F_CAFE_0001);
      exq[CH_B].push_back(64'd0);
      slv_b.push_back(2'b00);
      exq[CH_AR].push_back(64'h0000_0000_8000_0030);
      slv_r.push_back({2'b00, 32'h3333_3333});
      exq[CH_R1].push_back(64'h0000_0000_3333_3333);
      fork
        m1_write(32'h8000_0020, 32'hCAFE_0001, 4'hF);
        m1_read(32'h8000_0030);
      join
      drain();
      chk("write_before_read", 64'(ar1_bcnt), 64'(b_before + 1));
    end

    // slave stalls arready 5 cycles, m1 waits behind m0
    ar_delay = 5;
    exq[CH_AR].push_back(64'h0000_0000_8000_0050);
    exq[CH_AR].push_back(64'h0000_0000_8000_0060);
    slv_r.push_back({2'b00, 32'h5555_5555});
    slv_r.push_back({2'b00, 32'h6666_6666});
    exq[CH_R0].push_back(64'h0000_0000_5555_5555);
    exq[CH_R1].push_back(64'h0000_0000_6666_6666);
    fork
      m0_read(32'h8000_0050);
      begin
        repeat (2) @(posedge clk);
        m1_read(32'h8000_0060);
      end
    join
    drain();
    ar_delay = 0;

    // reset during RD_DATA, then a fresh m1 read with an error response
    begin
      logic seen;
      seen = 1'b0;
      r_delay = 4;
      exq[CH_AR].push_back(64'h0000_0000_8000_0070);
      slv_r.push_back({2'b00, 32'h7777_7777});
      exq[CH_R0].push_back(64'h0000_0000_7777_7777);
      m0_read(32'h8000_0070);
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (s_rready) begin
          seen = 1'b1;
          break;
        end
      end
      chk("reached_rd_data", 64'(seen), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_valids", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                                m0_rvalid, m1_rvalid, m1_bvalid}), 64'd0);
      chk("midrst_addr", 64'(s_araddr), 64'd0);
      exq[CH_R0].delete();
      slv_r.delete();
      repeat (6) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      r_delay = 0;
      exq[CH_AR].push_back(64'h0000_0000_8000_0040);
      slv_r.push_back({2'b10, 32'h0BAD_F00D});
      exq[CH_R1].push_back({30'd0, 2'b10, 32'h0BAD_F00D});
      m1_read(32'h8000_0040);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0: 0 = round-robin between masters; 1 = master 1 (data side) always wins ties.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 m0_araddr/m0_arvalid  input  32/1  master 0 (instruction side, read-only) read address channel; m0_arready output 1.
REQ-005 m0_rdata/m0_rresp/m0_rvalid  output  32/2/1  master 0 read data channel; m0_rready input 1.
REQ-006 m1_araddr/m1_arvalid  input  32/1  master 1 (data side) read address channel; m1_arready output 1.
REQ-007 m1_rdata/m1_rresp/m1_rvalid  output  32/2/1  master 1 read data channel; m1_rready input 1.
REQ-008 m1_awaddr/m1_awvalid, m1_wdata/m1_wstrb/m1_wvalid  input  32/1, 32/4/1  master 1 write address and data; m1_awready/m1_wready output 1 each.
REQ-009 m1_bresp/m1_bvalid  output  2/1  master 1 write response; m1_bready input 1.
REQ-010 s_araddr/s_arprot/s_arvalid  output  32/3/1  slave read address; s_arready input 1.
REQ-011 s_rdata/s_rresp/s_rvalid  input  32/2/1  slave read data; s_rready output 1.
REQ-012 s_awaddr/s_awprot/s_awvalid, s_wdata/s_wstrb/s_wvalid  output  32/3/1, 32/4/1  slave write address and data; s_awready/s_wready input 1 each.
REQ-013 s_bresp/s_bvalid  input  2/1  slave write response; s_bready output 1.

Function
REQ-014 States SHALL be IDLE, RD_ADDR, RD_DATA, WR_SEND, WR_RESP; one transaction in flight at a time.
REQ-015 s_arprot and s_awprot SHALL be constant 3'b000.
REQ-016 Request terms: req0 = m0_arvalid; req1 = m1_arvalid | (m1_awvalid & m1_wvalid).
REQ-017 In IDLE with only one reqX high, the arbiter SHALL grant master X.
REQ-018 In IDLE with both high: if FIXED_PRIORITY=1, grant m1; otherwise grant the master not in last_grant; last_grant updates on every grant.
REQ-019 Master 1 with both a write (awvalid&wvalid) and arvalid SHALL be granted the write first.
REQ-020 Read grant: mX_arready SHALL be combinationally high in the IDLE cycle of grant; araddr is latched into s_araddr; next state RD_ADDR with s_arvalid=1 from the following cycle.
REQ-021 Write grant: m1_awready and m1_wready SHALL both be high in the same IDLE cycle; awaddr/wdata/wstrb latched; next state WR_SEND with s_awvalid=s_wvalid=1.
REQ-022 RD_ADDR: hold s_arvalid and s_araddr stable until s_arready; on handshake drop s_arvalid, go RD_DATA.
REQ-023 RD_DATA: s_rready = granted mX_rready; granted mX_rvalid = s_rvalid; rdata/rresp passed through; the other master's rvalid SHALL be 0; on s_rvalid&s_rready go IDLE.
REQ-024 WR_SEND: s_awvalid and s_wvalid SHALL drop independently on their own handshakes (either order or same cycle); go WR_RESP when both have completed.
REQ-025 WR_RESP: s_bready = m1_bready; m1_bvalid = s_bvalid; bresp passed through; on s_bvalid&s_bready go IDLE.
REQ-026 Responses SHALL never be routed to a non-granted master; no m*_arready/awready/wready outside IDLE.
REQ-027 Minimum latency: grant cycle N, slave address valid N+1; back-to-back transactions need one IDLE cycle between.
REQ-028 Slave rresp/bresp error codes SHALL be forwarded unchanged; no retry.

Reset
REQ-029 With reset_n low, asynchronously: state=IDLE, last_grant=m1, all s_*valid, s_rready, s_bready, m*_rvalid, m1_bvalid = 0; latched address/data registers = 0.
REQ-030 Reset asserted mid-transaction SHALL abort it; the first post-reset request is arbitrated afresh.

Verification
REQ-031 Single read: m0_arvalid, araddr=0x8000_0000 -> m0_arready 1 cycle, s_araddr=0x8000_0000 next cycle; s_rdata=0xDEAD_BEEF -> m0_rdata=0xDEAD_BEEF, m0_rvalid 1 cycle.
REQ-032 Simultaneous m0/m1 reads after reset, FIXED_PRIORITY=0 -> m0 first, m1 second; repeat simultaneously -> m0, m1 alternation.
REQ-033 m1 write 0x1234_5678 to 0x8000_0010, strb 4'b0011, s_awready 2 cycles before s_wready -> s_awvalid drops first, single s_bready handshake, m1_bvalid 1 cycle.
REQ-034 m1 asserts arvalid and awvalid&wvalid together -> write completes before m1_arready goes high.
REQ-035 Slave stalls s_arready 5 cycles -> s_araddr/s_arvalid stable throughout; m1 request ignored until m0 completes.
REQ-036 reset_n low during RD_DATA -> all valids 0 immediately; after release, new m1 read completes normally.
